// File: rtl/branch_sequencer_pkg.sv
// Shared definitions for the IPPro program-counter sequencer: FSM state
// encodings and core-wide widths.
package branch_sequencer_pkg;

    localparam int unsigned PC_WIDTH_DEF = 10;
    localparam int unsigned FLAGS_LENGTH = 4;
    localparam int unsigned FLUSH_CNT_WIDTH = 3;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_RUN     = 3'd1,
        S_RESOLVE = 3'd2,
        S_FLUSH   = 3'd3,
        S_HALT    = 3'd4
    } seq_state_t;

endpackage

// File: rtl/branch_sequencer_sat_counter.sv
// Saturating up-counter with asynchronous reset; holds at all-ones instead
// of wrapping.
module sat_counter #(
    parameter int unsigned CNT_WIDTH = 16
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 INC,
    output logic [CNT_WIDTH-1:0] COUNT
);

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            COUNT <= '0;
        end else if (INC && (COUNT != '1)) begin
            COUNT <= COUNT + CNT_WIDTH'(1);
        end
    end

endmodule

// File: rtl/branch_sequencer.sv
// Program-counter sequencer: owns the PC, resolves branches through the
// retimed BRANCH_SEL, and flushes fetch/decode after every redirect.
module branch_sequencer
    import branch_sequencer_pkg::*;
#(
    parameter int unsigned PC_WIDTH     = PC_WIDTH_DEF,
    parameter int unsigned FLUSH_DEPTH  = 2,
    parameter int unsigned RESET_VECTOR = 0,
    parameter int unsigned CNT_WIDTH    = 16
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 EN,
    input  logic                 STALL,
    input  logic                 IS_BRANCH,
    input  logic                 IS_JUMP,
    input  logic                 IS_HALT,
    input  logic [PC_WIDTH-1:0]  BRANCH_TARGET,
    input  logic                 BRANCH_SEL,
    output logic [PC_WIDTH-1:0]  PC,
    output logic                 IM_RD_EN,
    output logic                 FLUSH,
    output logic                 HALTED,
    output logic [CNT_WIDTH-1:0] TAKEN_CNT
);

    localparam logic [PC_WIDTH-1:0]        RST_PC     = PC_WIDTH'(RESET_VECTOR);
    localparam logic [FLUSH_CNT_WIDTH-1:0] FLUSH_LOAD = FLUSH_CNT_WIDTH'(FLUSH_DEPTH);

    seq_state_t                 state_q, state_d;
    logic [PC_WIDTH-1:0]        pc_q, pc_d;
    logic [PC_WIDTH-1:0]        tgt_q, tgt_d;
    logic [FLUSH_CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic                       flush_q, flush_d;
    logic                       halted_q, halted_d;
    logic                       taken_inc;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q  <= S_IDLE;
            pc_q     <= RST_PC;
            tgt_q    <= '0;
            cnt_q    <= '0;
            flush_q  <= 1'b0;
            halted_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            tgt_q    <= tgt_d;
            cnt_q    <= cnt_d;
            flush_q  <= flush_d;
            halted_q <= halted_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        tgt_d     = tgt_q;
        cnt_d     = cnt_q;
        flush_d   = flush_q;
        halted_d  = halted_q;
        taken_inc = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (EN) begin
                    pc_d    = RST_PC;
                    state_d = S_RUN;
                end
            end

            S_RUN: begin
                if (!EN) begin
                    state_d = S_IDLE;
                    flush_d = 1'b0;
                    cnt_d   = '0;
                end else if (!STALL) begin
                    if (IS_HALT) begin
                        state_d  = S_HALT;
                        halted_d = 1'b1;
                    end else if (IS_JUMP) begin
                        pc_d      = BRANCH_TARGET;
                        taken_inc = 1'b1;
                        flush_d   = 1'b1;
                        cnt_d     = FLUSH_LOAD;
                        state_d   = S_FLUSH;
                    end else if (IS_BRANCH) begin
                        // PC holds: nothing is fetched until the branch resolves.
                        tgt_d   = BRANCH_TARGET;
                        state_d = S_RESOLVE;
                    end else begin
                        pc_d = pc_q + PC_WIDTH'(1);
                    end
                end
            end

            S_RESOLVE: begin
                // The branch unit retimes regardless of STALL, so BRANCH_SEL is
                // consumed here unconditionally.
                if (!EN) begin
                    state_d = S_IDLE;
                    flush_d = 1'b0;
                    cnt_d   = '0;
                end else if (BRANCH_SEL) begin
                    pc_d      = tgt_q;
                    taken_inc = 1'b1;
                    flush_d   = 1'b1;
                    cnt_d     = FLUSH_LOAD;
                    state_d   = S_FLUSH;
                end else begin
                    pc_d    = pc_q + PC_WIDTH'(1);
                    state_d = S_RUN;
                end
            end

            S_FLUSH: begin
                if (!EN) begin
                    state_d = S_IDLE;
                    flush_d = 1'b0;
                    cnt_d   = '0;
                end else if (!STALL) begin
                    if (cnt_q <= FLUSH_CNT_WIDTH'(1)) begin
                        flush_d = 1'b0;
                        cnt_d   = '0;
                        state_d = S_RUN;
                    end else begin
                        cnt_d = cnt_q - FLUSH_CNT_WIDTH'(1);
                    end
                end
            end

            S_HALT: begin
                if (!EN) begin
                    halted_d = 1'b0;
                    state_d  = S_IDLE;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    sat_counter #(
        .CNT_WIDTH(CNT_WIDTH)
    ) u_taken_cnt (
        .CLK  (CLK),
        .RST  (RST),
        .INC  (taken_inc),
        .COUNT(TAKEN_CNT)
    );

    assign PC       = pc_q;
    assign FLUSH    = flush_q;
    assign HALTED   = halted_q;
    assign IM_RD_EN = (state_q == S_RUN) && !STALL;

endmodule

// File: tb/tb_branch_sequencer.sv
// Self-checking bench for branch_sequencer: vector table, hand-written
// corner sequences and randomized stimulus against a behavioural model.
module tb_branch_sequencer;

    localparam int PCW   = 10;
    localparam int CW    = 8;
    localparam int FD    = 2;
    localparam int PCMOD = 1024;
    localparam int CMAX  = 255;

    logic            CLK;
    logic            RST;
    logic            EN;
    logic            STALL;
    logic            IS_BRANCH;
    logic            IS_JUMP;
    logic            IS_HALT;
    logic [PCW-1:0]  BRANCH_TARGET;
    logic            BRANCH_SEL;
    logic [PCW-1:0]  PC;
    logic            IM_RD_EN;
    logic            FLUSH;
    logic            HALTED;
    logic [CW-1:0]   TAKEN_CNT;

    branch_sequencer #(
        .PC_WIDTH    (PCW),
        .FLUSH_DEPTH (FD),
        .RESET_VECTOR(0),
        .CNT_WIDTH   (CW)
    ) dut (
        .CLK          (CLK),
        .RST          (RST),
        .EN           (EN),
        .STALL        (STALL),
        .IS_BRANCH    (IS_BRANCH),
        .IS_JUMP      (IS_JUMP),
        .IS_HALT      (IS_HALT),
        .BRANCH_TARGET(BRANCH_TARGET),
        .BRANCH_SEL   (BRANCH_SEL),
        .PC           (PC),
        .IM_RD_EN     (IM_RD_EN),
        .FLUSH        (FLUSH),
        .HALTED       (HALTED),
        .TAKEN_CNT    (TAKEN_CNT)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Behavioural model: "running" covers every non-idle, non-halted mode;
    // a pending branch and a remaining flush length refine it.
    int m_pc, m_tgt, m_flush, m_taken;
    bit m_run, m_halt, m_pend;

    task automatic model_reset();
        m_pc = 0; m_tgt = 0; m_flush = 0; m_taken = 0;
        m_run = 0; m_halt = 0; m_pend = 0;
    endtask

    task automatic model_redirect(input int target);
        m_pc    = target;
        m_taken = (m_taken < CMAX) ? m_taken + 1 : CMAX;
        m_flush = FD;
    endtask

    task automatic model_step();
        if (m_pend) begin
            m_pend = 0;
            if (!EN) m_run = 0;
            else if (BRANCH_SEL) model_redirect(m_tgt);
            else m_pc = (m_pc + 1) % PCMOD;
        end else if (m_halt) begin
            if (!EN) m_halt = 0;
        end else if (!m_run) begin
            if (EN) begin
                m_run = 1;
                m_pc  = 0;
            end
        end else if (m_flush > 0) begin
            if (!EN) begin
                m_run = 0;
                m_flush = 0;
            end else if (!STALL) m_flush--;
        end else if (!EN) begin
            m_run = 0;
        end else if (!STALL) begin
            if (IS_HALT) begin
                m_halt = 1;
                m_run  = 0;
            end else if (IS_JUMP) model_redirect(int'(BRANCH_TARGET));
            else if (IS_BRANCH) begin
                m_pend = 1;
                m_tgt  = int'(BRANCH_TARGET);
            end else m_pc = (m_pc + 1) % PCMOD;
        end
    endtask

    task automatic cyc(input int en, input int st, input int br, input int jp,
                       input int ht, input int tgt, input int sel);
        EN            = en[0];
        STALL         = st[0];
        IS_BRANCH     = br[0];
        IS_JUMP       = jp[0];
        IS_HALT       = ht[0];
        BRANCH_TARGET = tgt[PCW-1:0];
        BRANCH_SEL    = sel[0];
        @(posedge CLK);
        model_step();
        @(negedge CLK);
    endtask

    typedef struct {
        logic           en, st, br, jp, ht;
        logic [PCW-1:0] tgt;
        logic           sel;
        logic [PCW-1:0] pc;
        logic           fl, hl, rd;
        logic [CW-1:0]  tk;
    } vec_t;

    function automatic vec_t mk(int en, int st, int br, int jp, int ht, int tgt, int sel,
                                int pc, int fl, int hl, int rd, int tk);
        vec_t v;
        v.en = en[0]; v.st = st[0]; v.br = br[0]; v.jp = jp[0]; v.ht = ht[0];
        v.tgt = tgt[PCW-1:0]; v.sel = sel[0];
        v.pc = pc[PCW-1:0]; v.fl = fl[0]; v.hl = hl[0]; v.rd = rd[0];
        v.tk = tk[CW-1:0];
        return v;
    endfunction

    vec_t vq[$];

    initial begin
        logic [20:0] act_v, exp_v;
        logic [PCW-1:0] e_pc;
        logic [CW-1:0]  e_tk;
        logic           e_rd;

        // en st br jp ht tgt sel | pc fl hl rd tk
        vq.push_back(mk(1,0,0,0,0,0,0,      0,0,0,1,0));
        vq.push_back(mk(1,0,0,0,0,0,0,      1,0,0,1,0));
        vq.push_back(mk(1,0,0,0,0,0,0,      2,0,0,1,0));
        vq.push_back(mk(1,0,0,0,0,0,0,      3,0,0,1,0));
        vq.push_back(mk(1,0,0,0,0,0,0,      4,0,0,1,0));
        vq.push_back(mk(1,0,1,0,0,'h100,0,  4,0,0,0,0));
        vq.push_back(mk(1,0,0,0,0,0,1,      'h100,1,0,0,1));
        vq.push_back(mk(1,0,0,0,0,0,0,      'h100,1,0,0,1));
        vq.push_back(mk(1,0,0,0,0,0,0,      'h100,0,0,1,1));
        vq.push_back(mk(1,0,0,0,0,0,0,      'h101,0,0,1,1));
        vq.push_back(mk(1,0,1,0,0,'h200,0,  'h101,0,0,0,1));
        vq.push_back(mk(1,0,0,0,0,0,0,      'h102,0,0,1,1));
        vq.push_back(mk(1,0,0,0,0,0,0,      'h103,0,0,1,1));
        vq.push_back(mk(1,0,0,1,0,'h3FF,0,  'h3FF,1,0,0,2));
        vq.push_back(mk(1,1,0,0,0,0,0,      'h3FF,1,0,0,2));
        vq.push_back(mk(1,1,0,0,0,0,0,      'h3FF,1,0,0,2));
        vq.push_back(mk(1,1,0,0,0,0,0,      'h3FF,1,0,0,2));
        vq.push_back(mk(1,0,0,0,0,0,0,      'h3FF,1,0,0,2));
        vq.push_back(mk(1,0,0,0,0,0,0,      'h3FF,0,0,1,2));
        vq.push_back(mk(1,0,0,0,0,0,0,      0,0,0,1,2));
        vq.push_back(mk(1,1,0,0,0,0,0,      0,0,0,0,2));
        vq.push_back(mk(1,0,1,1,1,'h123,1,  0,0,1,0,2));
        vq.push_back(mk(1,0,0,0,0,0,0,      0,0,1,0,2));
        vq.push_back(mk(0,0,0,0,0,0,0,      0,0,0,0,2));
        vq.push_back(mk(0,0,0,0,0,0,0,      0,0,0,0,2));
        vq.push_back(mk(1,0,0,0,0,0,0,      0,0,0,1,2));

        RST = 1'b1; EN = 1'b0; STALL = 1'b0; IS_BRANCH = 1'b0; IS_JUMP = 1'b0;
        IS_HALT = 1'b0; BRANCH_TARGET = '0; BRANCH_SEL = 1'b0;
        model_reset();
        @(negedge CLK);
        @(negedge CLK);
        chk("reset pc", 64'(PC), 64'd0);
        chk("reset flush", 64'(FLUSH), 64'd0);
        chk("reset halted", 64'(HALTED), 64'd0);
        chk("reset rd_en", 64'(IM_RD_EN), 64'd0);
        chk("reset taken", 64'(TAKEN_CNT), 64'd0);
        RST = 1'b0;

        foreach (vq[i]) begin
            cyc(int'(vq[i].en), int'(vq[i].st), int'(vq[i].br), int'(vq[i].jp),
                int'(vq[i].ht), int'(vq[i].tgt), int'(vq[i].sel));
            chk($sformatf("vec%0d pc", i), 64'(PC), 64'(vq[i].pc));
            chk($sformatf("vec%0d flush", i), 64'(FLUSH), 64'(vq[i].fl));
            chk($sformatf("vec%0d halted", i), 64'(HALTED), 64'(vq[i].hl));
            chk($sformatf("vec%0d rd_en", i), 64'(IM_RD_EN), 64'(vq[i].rd));
            chk($sformatf("vec%0d taken", i), 64'(TAKEN_CNT), 64'(vq[i].tk));
        end

        // EN dropped while a branch is resolving: BRANCH_SEL=1 must be ignored.
        cyc(1,0,0,0,0,0,0);
        cyc(1,0,0,0,0,0,0);
        cyc(1,0,1,0,0,'h55,0);
        chk("abort resolve rd_en", 64'(IM_RD_EN), 64'd0);
        chk("abort resolve pc", 64'(PC), 64'd2);
        cyc(0,0,0,0,0,0,1);
        chk("abort pc", 64'(PC), 64'd2);
        chk("abort taken", 64'(TAKEN_CNT), 64'd2);
        chk("abort flush", 64'(FLUSH), 64'd0);
        cyc(0,0,0,0,0,0,1);
        chk("abort idle pc", 64'(PC), 64'd2);
        chk("abort idle rd_en", 64'(IM_RD_EN), 64'd0);

        // Asynchronous reset in the middle of a flush.
        cyc(1,0,0,0,0,0,0);
        chk("restart pc", 64'(PC), 64'd0);
        cyc(1,0,0,1,0,'h2A,0);
        chk("jump2 pc", 64'(PC), 64'h2A);
        chk("jump2 flush", 64'(FLUSH), 64'd1);
        chk("jump2 taken", 64'(TAKEN_CNT), 64'd3);
        RST = 1'b1;
        #1;
        chk("midflush rst pc", 64'(PC), 64'd0);
        chk("midflush rst flush", 64'(FLUSH), 64'd0);
        chk("midflush rst halted", 64'(HALTED), 64'd0);
        chk("midflush rst rd_en", 64'(IM_RD_EN), 64'd0);
        chk("midflush rst taken", 64'(TAKEN_CNT), 64'd0);
        @(negedge CLK);
        RST = 1'b0;
        model_reset();

        // Saturation of the taken counter.
        cyc(1,0,0,0,0,0,0);
        for (int i = 0; i < 300; i++) begin
            cyc(1,0,0,1,0,i,0);
            if (i == 253) chk("sat 254", 64'(TAKEN_CNT), 64'd254);
            if (i == 254) chk("sat 255", 64'(TAKEN_CNT), 64'd255);
            cyc(1,0,0,0,0,0,0);
            cyc(1,0,0,0,0,0,0);
        end
        chk("sat hold", 64'(TAKEN_CNT), 64'd255);
        chk("sat pc", 64'(PC), 64'(299));

        // Randomized run against the model.
        RST = 1'b1;
        @(negedge CLK);
        RST = 1'b0;
        model_reset();
        for (int n = 0; n < 4000; n++) begin
            cyc(int'($urandom_range(0, 29) != 0), int'($urandom_range(0, 3) == 0),
                int'($urandom_range(0, 6) == 0), int'($urandom_range(0, 11) == 0),
                int'($urandom_range(0, 39) == 0), int'($urandom_range(0, 1023)),
                int'($urandom_range(0, 1)));
            e_pc  = m_pc[PCW-1:0];
            e_tk  = m_taken[CW-1:0];
            e_rd  = m_run && !m_pend && (m_flush == 0) && !STALL;
            act_v = {PC, FLUSH, HALTED, IM_RD_EN, TAKEN_CNT};
            exp_v = {e_pc, (m_flush > 0), m_halt, e_rd, e_tk};
            chk($sformatf("rand%0d {pc,flush,halted,rd,taken}", n), 64'(act_v), 64'(exp_v));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
